tff_count_ctrl: RTL and testbench



---
 rtl/tff_count_ctrl_if.sv | 25 ++
 rtl/tff_count_ctrl.sv | 138 +++++++++++++
 tb/tb_tff_count_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tff_count_ctrl_if.sv
// rtl/tff_count_ctrl_if.sv - control/status bundle between a TFF bank sequencer and its bank
interface tff_count_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic         stop;
  logic         mode_up;
  logic [W-1:0] q_in;
  logic [W-1:0] t_en;
  logic         bank_clear;
  logic         busy;
  logic         done;
  logic         wrap;
  logic         err;

  modport master (
    output start, stop, mode_up, q_in,
    input  t_en, bank_clear, busy, done, wrap, err
  );

  modport slave (
    input  start, stop, mode_up, q_in,
    output t_en, bank_clear, busy, done, wrap, err
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - sequencer driving a toggle-flip-flop bank as a modulo-MOD up/down counter
module tff_count_ctrl #(
  parameter int W        = 4,
  parameter int MOD      = 10,
  parameter int DIV      = 1,
  parameter int ONE_SHOT = 0
) (
  input logic           clock,
  input logic           clear,
  tff_count_ctrl_if.slave bus
);

  localparam int            WP      = W + 1;
  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W:0]    MOD_W   = WP'(MOD);
  localparam logic [W:0]    TOP_W   = WP'(MOD - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
  localparam logic          ONESHOT = (ONE_SHOT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ps;
  logic [PW-1:0] ps_nxt;
  logic          step;
  logic          bank_clear_nxt;

  logic [W:0]    q_ext;
  logic [W:0]    nxt_cnt;
  logic          in_range;
  logic          at_wrap;
  logic [W-1:0]  flip;

  logic [W-1:0]  t_en_q;
  logic          wrap_q;
  logic          err_q;
  logic          bank_clear_q;

  // Next count is formed one bit wider so MOD == 2**W compares without overflow.
  always_comb begin
    q_ext    = {1'b0, bus.q_in};
    in_range = (q_ext < MOD_W);
    at_wrap  = 1'b0;
    nxt_cnt  = '0;
    if (in_range) begin
      if (bus.mode_up) begin
        at_wrap = (q_ext == TOP_W);
        nxt_cnt = at_wrap ? '0 : q_ext + 1'b1;
      end else begin
        at_wrap = (q_ext == '0);
        nxt_cnt = at_wrap ? TOP_W : q_ext - 1'b1;
      end
    end
    flip = W'(q_ext ^ nxt_cnt);
  end

  always_comb begin
    state_nxt      = state;
    ps_nxt         = ps;
    step           = 1'b0;
    bank_clear_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        ps_nxt = '0;
        if (bus.start) begin
          state_nxt      = S_CLR;
          bank_clear_nxt = 1'b1;
        end
      end
      S_CLR: begin
        ps_nxt    = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_PAUSE;
        end else if (ps == PS_LAST) begin
          ps_nxt = '0;
          step   = 1'b1;
          if (ONESHOT && at_wrap) state_nxt = S_DONE;
        end else begin
          ps_nxt = ps + 1'b1;
        end
      end
      S_PAUSE: begin
        // Prescaler is left untouched so a resume completes the interrupted interval.
        if (bus.stop) begin
          state_nxt      = S_IDLE;
          bank_clear_nxt = 1'b1;
        end else if (bus.start) begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (bus.start) begin
          state_nxt      = S_CLR;
          bank_clear_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= S_IDLE;
      ps           <= '0;
      t_en_q       <= '0;
      wrap_q       <= 1'b0;
      err_q        <= 1'b0;
      bank_clear_q <= 1'b1;
    end else begin
      state        <= state_nxt;
      ps           <= ps_nxt;
      t_en_q       <= step ? flip : '0;
      wrap_q       <= step & at_wrap;
      bank_clear_q <= bank_clear_nxt;
      if (step && !in_range) err_q <= 1'b1;
    end
  end

  assign bus.t_en       = t_en_q;
  assign bus.wrap       = wrap_q;
  assign bus.err        = err_q;
  assign bus.bank_clear = bank_clear_q;
  assign bus.busy       = (state == S_CLR) || (state == S_RUN) || (state == S_PAUSE);
  assign bus.done       = (state == S_DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed vector bench for tff_count_ctrl with behavioural TFF banks
module tb_tff_count_ctrl;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  tff_count_ctrl_if #(.W(4)) ia ();
  tff_count_ctrl_if #(.W(4)) ib ();
  tff_count_ctrl_if #(.W(4)) ic ();

  tff_count_ctrl #(.W(4), .MOD(10), .DIV(1), .ONE_SHOT(0)) u_a (.clock(clock), .clear(clear), .bus(ia));
  tff_count_ctrl #(.W(4), .MOD(10), .DIV(4), .ONE_SHOT(0)) u_b (.clock(clock), .clear(clear), .bus(ib));
  tff_count_ctrl #(.W(4), .MOD(10), .DIV(1), .ONE_SHOT(1)) u_c (.clock(clock), .clear(clear), .bus(ic));

  logic [3:0] qa = '0;
  logic [3:0] qb = '0;
  logic [3:0] qc = '0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = '0;

  // Banks settle mid-cycle so the sequencer sees the new count at the next edge.
  always @(negedge clock) begin
    qa <= ia.bank_clear ? 4'h0 : qa ^ ia.t_en;
    qb <= ib.bank_clear ? 4'h0 : qb ^ ib.t_en;
    qc <= ic.bank_clear ? 4'h0 : qc ^ ic.t_en;
  end

  assign ia.q_in = force_en ? force_val : qa;
  assign ib.q_in = qb;
  assign ic.q_in = qc;

  typedef struct {
    logic       start;
    logic       stop;
    logic       up;
    logic [3:0] t_en;
    logic       wrap;
    logic       busy;
    logic       done;
    logic       bc;
  } vec_t;

  vec_t tbl[$];
  int   n_applied = 0;
  int   n_miss    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic st, input logic u, input logic [3:0] t,
                     input logic w, input logic bz, input logic dn, input logic bc);
    vec_t v;
    v.start = s; v.stop = st; v.up = u; v.t_en = t;
    v.wrap = w; v.busy = bz; v.done = dn; v.bc = bc;
    tbl.push_back(v);
  endtask

  logic [3:0] up_ten [10];

  initial begin
    ia.start = 0; ia.stop = 0; ia.mode_up = 1;
    ib.start = 0; ib.stop = 0; ib.mode_up = 1;
    ic.start = 0; ic.stop = 0; ic.mode_up = 1;
    up_ten = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF, 4'h1, 4'h9};

    //    st  sp  up  t_en  wr  bz  dn  bc
    add(1, 0, 1, 4'h0, 0, 1, 0, 1);
    add(0, 0, 1, 4'h0, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 0, 1, 4'h3, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 0, 1, 4'h7, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 0, 1, 4'h3, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 0, 1, 4'hF, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 0, 1, 4'h9, 1, 1, 0, 0);
    add(0, 0, 0, 4'h9, 1, 1, 0, 0);
    add(0, 0, 0, 4'h1, 0, 1, 0, 0);
    add(1, 1, 0, 4'h0, 0, 1, 0, 0);
    add(0, 0, 0, 4'h0, 0, 1, 0, 0);
    add(1, 1, 0, 4'h0, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 0, 4'h0, 0, 0, 0, 0);
    add(1, 0, 1, 4'h0, 0, 1, 0, 1);
    add(0, 0, 1, 4'h0, 0, 1, 0, 0);
    add(0, 0, 1, 4'h1, 0, 1, 0, 0);
    add(0, 1, 1, 4'h0, 0, 1, 0, 0);
    add(1, 0, 1, 4'h0, 0, 1, 0, 0);
    add(0, 0, 1, 4'h3, 0, 1, 0, 0);

    tick(); tick();
    chk("reset t_en", ia.t_en, 4'h0);
    chk("reset wrap", ia.wrap, 1'b0);
    chk("reset err", ia.err, 1'b0);
    chk("reset done", ia.done, 1'b0);
    chk("reset busy", ia.busy, 1'b0);
    chk("reset bank_clear", ia.bank_clear, 1'b1);
    clear = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      ia.start = tbl[i].start; ia.stop = tbl[i].stop; ia.mode_up = tbl[i].up;
      tick();
      chk($sformatf("v%0d t_en", i), ia.t_en, tbl[i].t_en);
      chk($sformatf("v%0d wrap", i), ia.wrap, tbl[i].wrap);
      chk($sformatf("v%0d busy", i), ia.busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), ia.done, tbl[i].done);
      chk($sformatf("v%0d bank_clear", i), ia.bank_clear, tbl[i].bc);
    end
    ia.start = 0; ia.stop = 0; ia.mode_up = 1;

    // clear mid-run at q=5, then an out-of-range bank value at a step
    tick(); chk("a 2->3", ia.t_en, 4'h1);
    tick(); chk("a 3->4", ia.t_en, 4'h7);
    tick(); chk("a 4->5", ia.t_en, 4'h1);
    #5 chk("a q before clear", qa, 4'h5);
    clear = 1;
    tick();
    chk("clr t_en", ia.t_en, 4'h0);
    chk("clr bank_clear", ia.bank_clear, 1'b1);
    chk("clr busy", ia.busy, 1'b0);
    clear = 0;
    tick(); chk("idle bank_clear", ia.bank_clear, 1'b0);
    ia.start = 1; tick(); ia.start = 0; tick();
    force_en = 1; force_val = 4'hC;
    tick();
    force_en = 0;
    chk("oor t_en", ia.t_en, 4'hC);
    chk("oor err", ia.err, 1'b1);
    chk("oor wrap", ia.wrap, 1'b0);
    tick(); chk("oor2 t_en", ia.t_en, 4'hC);
    tick(); chk("post oor t_en", ia.t_en, 4'h1);
    chk("err sticky run", ia.err, 1'b1);
    ia.stop = 1; tick(); tick();
    chk("err sticky idle", ia.err, 1'b1);
    chk("pause abort busy", ia.busy, 1'b0);
    ia.stop = 0;
    clear = 1; tick(); chk("err cleared", ia.err, 1'b0);
    clear = 0; tick();

    // DIV=4 with pause two edges into an interval
    ib.start = 1; tick(); chk("b clr", ib.bank_clear, 1'b1);
    ib.start = 0; tick();
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("b gap%0d", k), ib.t_en, 4'h0);
    end
    tick(); chk("b step1", ib.t_en, 4'h1);
    tick(); tick(); chk("b mid", ib.t_en, 4'h0);
    ib.stop = 1; tick();
    chk("b pause t_en", ib.t_en, 4'h0);
    chk("b pause busy", ib.busy, 1'b1);
    ib.stop = 0; tick(); tick(); chk("b held", ib.t_en, 4'h0);
    ib.start = 1; tick(); chk("b resume", ib.t_en, 4'h0);
    ib.start = 0; tick(); chk("b resume+1", ib.t_en, 4'h0);
    tick(); chk("b resume+2 step", ib.t_en, 4'h3);

    // one-shot: stop in DONE after the wrapping step, then restart
    ic.start = 1; tick(); ic.start = 0; tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("c step%0d t_en", k), ic.t_en, up_ten[k]);
      chk($sformatf("c step%0d wrap", k), ic.wrap, (k == 9));
      chk($sformatf("c step%0d done", k), ic.done, (k == 9));
    end
    chk("c busy after wrap", ic.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("c hold%0d t_en", k), ic.t_en, 4'h0);
      chk($sformatf("c hold%0d done", k), ic.done, 1'b1);
    end
    ic.start = 1; tick();
    chk("c restart bank_clear", ic.bank_clear, 1'b1);
    chk("c restart busy", ic.busy, 1'b1);
    chk("c restart done", ic.done, 1'b0);
    ic.start = 0; tick(); tick();
    chk("c restart step", ic.t_en, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
